// File: rtl/clock_set_controller_if.sv
// rtl/clock_set_controller_if.sv - button/live-time inputs and load/edit outputs of the clock set controller
// Optional BLINK_EN adds the blink output.
interface clock_set_controller_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       cur_isPM;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic       clk_run;
    logic       load;
    logic       load_isPM;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;
    logic [5:0] load_seconds;
    logic [1:0] set_field;
    logic [5:0] edit_value;
`ifdef BLINK_EN
    logic       blink;
`endif

    modport slave (
        input  tick, btn_mode, btn_up, btn_down,
        input  cur_isPM, cur_hours, cur_minutes, cur_seconds,
        output clk_run, load, load_isPM, load_hours, load_minutes, load_seconds,
        output set_field, edit_value
`ifdef BLINK_EN
        , output blink
`endif
    );

    modport master (
        output tick, btn_mode, btn_up, btn_down,
        output cur_isPM, cur_hours, cur_minutes, cur_seconds,
        input  clk_run, load, load_isPM, load_hours, load_minutes, load_seconds,
        input  set_field, edit_value
`ifdef BLINK_EN
        , input blink
`endif
    );
endinterface

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - RUN/SET_HOUR/SET_MIN/SET_SEC time-setting sequencer for NormalClock
// Optional BLINK_EN adds a tick-toggled blink output while editing.
module clock_set_controller #(
    parameter int unsigned TIMEOUT_TICKS = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    clock_set_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    localparam logic [5:0] TERM_CNT = 6'(TIMEOUT_TICKS - 1);

    state_t     r_state;
    logic [2:0] r_btn_q;
    logic [4:0] r_sh_h;
    logic [5:0] r_sh_m;
    logic [5:0] r_sh_s;
    logic [5:0] r_cnt;
    logic       r_clk_run;
    logic       r_load;
    logic       r_load_isPM;
    logic [4:0] r_load_hours;
    logic [5:0] r_load_minutes;
    logic [5:0] r_load_seconds;
    logic [1:0] r_set_field;
    logic [5:0] r_edit_value;

    logic       w_mode_e;
    logic       w_up_e;
    logic       w_dn_e;
    logic       w_any_e;
    logic       w_step;
    state_t     w_nxt_state;
    logic [4:0] w_nxt_h;
    logic [5:0] w_nxt_m;
    logic [5:0] w_nxt_s;
    logic [5:0] w_nxt_edit;
    logic       w_do_load;

    function automatic logic [4:0] f_step_h(input logic [4:0] v, input logic up);
        if (up) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] f_step_60(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // History regs reset high so a button held through reset never produces an edge.
    assign w_mode_e = bus.btn_mode & ~r_btn_q[2];
    assign w_up_e   = bus.btn_up   & ~r_btn_q[1];
    assign w_dn_e   = bus.btn_down & ~r_btn_q[0];
    assign w_any_e  = w_mode_e | w_up_e | w_dn_e;
    assign w_step   = w_up_e ^ w_dn_e;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_h     = r_sh_h;
        w_nxt_m     = r_sh_m;
        w_nxt_s     = r_sh_s;
        w_do_load   = 1'b0;
        if (r_state == RUN) begin
            if (w_mode_e) begin
                w_nxt_state = SET_HOUR;
                w_nxt_h     = bus.cur_hours + (bus.cur_isPM ? 5'd12 : 5'd0);
                w_nxt_m     = bus.cur_minutes;
                w_nxt_s     = bus.cur_seconds;
            end
        end else if (w_mode_e) begin
            case (r_state)
                SET_HOUR: w_nxt_state = SET_MIN;
                SET_MIN:  w_nxt_state = SET_SEC;
                default: begin
                    w_nxt_state = RUN;
                    w_do_load   = 1'b1;
                end
            endcase
        end else if (w_any_e) begin
            // up+down together is an edge (resets the timeout) but edits nothing
            if (w_step) begin
                case (r_state)
                    SET_HOUR: w_nxt_h = f_step_h(r_sh_h, w_up_e);
                    SET_MIN:  w_nxt_m = f_step_60(r_sh_m, w_up_e);
                    default:  w_nxt_s = f_step_60(r_sh_s, w_up_e);
                endcase
            end
        end else if (bus.tick && (r_cnt >= TERM_CNT)) begin
            w_nxt_state = RUN;
        end
    end

    always_comb begin
        w_nxt_edit = 6'd0;
        case (w_nxt_state)
            SET_HOUR: w_nxt_edit = {1'b0, w_nxt_h};
            SET_MIN:  w_nxt_edit = w_nxt_m;
            SET_SEC:  w_nxt_edit = w_nxt_s;
            default:  w_nxt_edit = 6'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= RUN;
            r_btn_q        <= 3'b111;
            r_sh_h         <= 5'd0;
            r_sh_m         <= 6'd0;
            r_sh_s         <= 6'd0;
            r_cnt          <= 6'd0;
            r_clk_run      <= 1'b1;
            r_load         <= 1'b0;
            r_load_isPM    <= 1'b0;
            r_load_hours   <= 5'd0;
            r_load_minutes <= 6'd0;
            r_load_seconds <= 6'd0;
            r_set_field    <= 2'd0;
            r_edit_value   <= 6'd0;
        end else begin
            r_btn_q      <= {bus.btn_mode, bus.btn_up, bus.btn_down};
            r_state      <= w_nxt_state;
            r_sh_h       <= w_nxt_h;
            r_sh_m       <= w_nxt_m;
            r_sh_s       <= w_nxt_s;
            r_clk_run    <= (w_nxt_state == RUN);
            r_load       <= w_do_load;
            r_set_field  <= 2'(w_nxt_state);
            r_edit_value <= w_nxt_edit;
            if ((r_state == RUN) || (w_nxt_state == RUN) || w_any_e) begin
                r_cnt <= 6'd0;
            end else if (bus.tick && (r_cnt != 6'h3f)) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_do_load) begin
                r_load_isPM    <= (r_sh_h >= 5'd12);
                r_load_hours   <= (r_sh_h >= 5'd12) ? r_sh_h - 5'd12 : r_sh_h;
                r_load_minutes <= r_sh_m;
                r_load_seconds <= r_sh_s;
            end
        end
    end

`ifdef BLINK_EN
    logic r_blink;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink <= 1'b0;
        end else if (w_nxt_state == RUN) begin
            r_blink <= 1'b0;
        end else if (r_state == RUN) begin
            r_blink <= 1'b1;
        end else if (bus.tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign bus.blink = r_blink;
`endif

    assign bus.clk_run      = r_clk_run;
    assign bus.load         = r_load;
    assign bus.load_isPM    = r_load_isPM;
    assign bus.load_hours   = r_load_hours;
    assign bus.load_minutes = r_load_minutes;
    assign bus.load_seconds = r_load_seconds;
    assign bus.set_field    = r_set_field;
    assign bus.edit_value   = r_edit_value;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed vector bench for clock_set_controller (BLINK_EN optional)
module tb_clock_set_controller;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   load_seen = 0;

    clock_set_controller_if u_if ();

    clock_set_controller #(.TIMEOUT_TICKS(30)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (u_if.load === 1'b1) load_seen++;

    typedef struct {
        logic       m, u, d;
        logic       pm;
        logic [4:0] ch;
        logic [5:0] cm, cs;
        logic [1:0] e_sf;
        logic [5:0] e_ev;
        logic       e_load;
        logic       e_lpm;
        logic [4:0] e_lh;
        logic [5:0] e_lm, e_ls;
    } vec_t;

    vec_t       vecs[$];
    logic       c_pm;
    logic [4:0] c_h;
    logic [5:0] c_m, c_s;
    logic       l_pm;
    logic [4:0] l_h;
    logic [5:0] l_m, l_s;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic m, u, d, input int sf, ev, input logic ld);
        vec_t v;
        v.m = m; v.u = u; v.d = d;
        v.pm = c_pm; v.ch = c_h; v.cm = c_m; v.cs = c_s;
        v.e_sf = 2'(sf); v.e_ev = 6'(ev); v.e_load = ld;
        v.e_lpm = l_pm; v.e_lh = l_h; v.e_lm = l_m; v.e_ls = l_s;
        vecs.push_back(v);
    endtask

    task automatic step(input logic m, u, d, t);
        u_if.btn_mode = m;
        u_if.btn_up   = u;
        u_if.btn_down = d;
        u_if.tick     = t;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ld0;
        u_if.tick = 0; u_if.btn_mode = 1; u_if.btn_up = 0; u_if.btn_down = 0;
        u_if.cur_isPM = 0; u_if.cur_hours = 0; u_if.cur_minutes = 0; u_if.cur_seconds = 0;

        // reset state, then release with mode held high
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_run", u_if.clk_run, 1);
        check("rst_load", u_if.load, 0);
        check("rst_set_field", u_if.set_field, 0);
        check("rst_edit_value", u_if.edit_value, 0);
        check("rst_load_hours", u_if.load_hours, 0);
        check("rst_load_minutes", u_if.load_minutes, 0);
        check("rst_load_seconds", u_if.load_seconds, 0);
        check("rst_load_isPM", u_if.load_isPM, 0);
`ifdef BLINK_EN
        check("rst_blink", u_if.blink, 0);
`endif
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0);
            check("held_sf", u_if.set_field, 0);
            check("held_run", u_if.clk_run, 1);
            check("held_load", u_if.load, 0);
        end
        step(0, 0, 0, 0);
        check("held_rel_sf", u_if.set_field, 0);

        // table: 11 PM 59:58, hour wrap, load of 0 AM 59:58
        l_pm = 0; l_h = 0; l_m = 0; l_s = 0;
        c_pm = 1; c_h = 11; c_m = 59; c_s = 58;
        add(0,0,0, 0, 0, 0);
        add(1,0,0, 1,23, 0);
        add(0,1,0, 1, 0, 0);
        add(0,0,0, 1, 0, 0);
        add(0,1,0, 1, 1, 0);
        add(0,0,0, 1, 1, 0);
        add(0,0,1, 1, 0, 0);
        add(0,0,0, 1, 0, 0);
        add(0,0,1, 1,23, 0);
        add(0,0,0, 1,23, 0);
        add(0,1,0, 1, 0, 0);
        add(0,0,0, 1, 0, 0);
        add(1,0,0, 2,59, 0);
        add(0,0,0, 2,59, 0);
        add(0,1,1, 2,59, 0);
        add(0,0,0, 2,59, 0);
        add(0,1,0, 2, 0, 0);
        add(0,0,0, 2, 0, 0);
        add(0,0,1, 2,59, 0);
        add(0,0,0, 2,59, 0);
        add(1,0,0, 3,58, 0);
        add(0,0,0, 3,58, 0);
        add(0,0,1, 3,57, 0);
        add(0,0,0, 3,57, 0);
        add(0,1,0, 3,58, 0);
        add(0,0,0, 3,58, 0);
        l_pm = 0; l_h = 0; l_m = 59; l_s = 58;
        add(1,1,0, 0, 0, 1);
        add(1,0,0, 0, 0, 0);
        add(0,0,0, 0, 0, 0);
        add(0,1,0, 0, 0, 0);
        add(0,0,0, 0, 0, 0);
        // table: 12 PM 00:59, minute 0->59 wrap, up+down, held up, load of 0 PM 00:59
        c_pm = 1; c_h = 0; c_m = 0; c_s = 59;
        add(1,0,0, 1,12, 0);
        add(0,0,0, 1,12, 0);
        add(0,0,1, 1,11, 0);
        add(0,0,0, 1,11, 0);
        add(0,1,0, 1,12, 0);
        add(0,0,0, 1,12, 0);
        add(1,0,0, 2, 0, 0);
        add(0,0,0, 2, 0, 0);
        add(0,0,1, 2,59, 0);
        add(0,0,0, 2,59, 0);
        add(0,1,1, 2,59, 0);
        add(0,0,0, 2,59, 0);
        add(0,1,0, 2, 0, 0);
        add(0,1,0, 2, 0, 0);
        add(0,0,0, 2, 0, 0);
        add(1,0,0, 3,59, 0);
        add(0,0,0, 3,59, 0);
        add(0,1,0, 3, 0, 0);
        add(0,0,0, 3, 0, 0);
        add(0,0,1, 3,59, 0);
        add(0,0,0, 3,59, 0);
        l_pm = 1; l_h = 0; l_m = 0; l_s = 59;
        add(1,0,0, 0, 0, 1);
        add(0,0,0, 0, 0, 0);

        foreach (vecs[i]) begin
            u_if.cur_isPM    = vecs[i].pm;
            u_if.cur_hours   = vecs[i].ch;
            u_if.cur_minutes = vecs[i].cm;
            u_if.cur_seconds = vecs[i].cs;
            step(vecs[i].m, vecs[i].u, vecs[i].d, 0);
            check($sformatf("v%0d_set_field", i), u_if.set_field, vecs[i].e_sf);
            check($sformatf("v%0d_edit_value", i), u_if.edit_value, vecs[i].e_ev);
            check($sformatf("v%0d_clk_run", i), u_if.clk_run, (vecs[i].e_sf == 2'd0) ? 1 : 0);
            check($sformatf("v%0d_load", i), u_if.load, vecs[i].e_load);
            check($sformatf("v%0d_load_isPM", i), u_if.load_isPM, vecs[i].e_lpm);
            check($sformatf("v%0d_load_hours", i), u_if.load_hours, vecs[i].e_lh);
            check($sformatf("v%0d_load_minutes", i), u_if.load_minutes, vecs[i].e_lm);
            check($sformatf("v%0d_load_seconds", i), u_if.load_seconds, vecs[i].e_ls);
        end

        // timeout after 30 idle ticks, no load
        ld0 = load_seen;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("to_enter_sf", u_if.set_field, 1);
        ticks(29);
        check("to_t29_sf", u_if.set_field, 1);
        check("to_t29_run", u_if.clk_run, 0);
        step(0, 0, 0, 1);
        check("to_t30_sf", u_if.set_field, 0);
        check("to_t30_run", u_if.clk_run, 1);
        step(0, 0, 0, 0);
        check("to_no_load", load_seen - ld0, 0);

        // press on tick 29 restarts the count
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        ticks(28);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        check("p29_sf", u_if.set_field, 1);
        check("p29_ev", u_if.edit_value, 13);
        ticks(29);
        check("p29_hold_sf", u_if.set_field, 1);
        step(0, 0, 0, 1);
        check("p29_expire_sf", u_if.set_field, 0);

        // edge on the terminal tick beats the timeout
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        ticks(29);
        step(0, 0, 1, 1);
        check("term_edge_sf", u_if.set_field, 1);
        check("term_edge_ev", u_if.edit_value, 11);
        step(0, 0, 0, 0);
        ticks(29);
        check("term_hold_sf", u_if.set_field, 1);
        step(0, 0, 0, 1);
        check("term_expire_sf", u_if.set_field, 0);
        check("term_expire_run", u_if.clk_run, 1);
        check("timeouts_no_load", load_seen - ld0, 0);

`ifdef BLINK_EN
        step(1, 0, 0, 0);
        check("blink_entry", u_if.blink, 1);
        step(0, 0, 0, 1);
        check("blink_t1", u_if.blink, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("blink_t2", u_if.blink, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("blink_t3", u_if.blink, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        check("blink_run_sf", u_if.set_field, 0);
        check("blink_run", u_if.blink, 0);
`endif

        // asynchronous reset in SET_SEC discards the edit
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        check("mid_sf_sec", u_if.set_field, 3);
        ld0 = load_seen;
        #2;
        reset = 1'b0;
        #1;
        check("mid_async_run", u_if.clk_run, 1);
        check("mid_async_sf", u_if.set_field, 0);
        check("mid_async_load", u_if.load, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            check("mid_after_sf", u_if.set_field, 0);
            check("mid_after_run", u_if.clk_run, 1);
        end
        check("mid_no_load", load_seen - ld0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
